// File: rtl/instruction_fetch_scheduler.sv
// Fetches instruction blocks from a double-buffered memory in address order and streams them to the decoder.
// Latency: 3 cycles from block-ready to inst_valid; read issue is gated by free FIFO space, so the decoder's ready never loses data.
module instruction_fetch_scheduler #(
  parameter int INST_DATA_WIDTH = 32,
  parameter int INST_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0] BLOCK_END_OPCODE = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                num_blocks,
  input  logic                       imem_block_ready,
  output logic                       imem_rd_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic                       imem_rd_valid,
  input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
  output logic                       imem_rd_block_done,
  output logic                       inst_valid,
  output logic [INST_DATA_WIDTH-1:0] inst_data,
  input  logic                       inst_ready,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                blocks_done,
  output logic                       err_no_end
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_FETCH, S_DRAIN, S_RETIRE, S_DONE
  } state_t;

  state_t                     state;
  logic [INST_ADDR_WIDTH-1:0] iss_ptr;
  logic [INST_ADDR_WIDTH-1:0] rsp_ptr;
  logic                       pend;
  logic [15:0]                nblk;
  logic [INST_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  logic rsp_ok, rsp_drop, is_end_op, at_max, end_now, issue, pop, has_room;

  always_comb begin
    rsp_ok    = (state == S_FETCH) && pend && imem_rd_valid;
    rsp_drop  = (state == S_FETCH) && pend && !imem_rd_valid;
    is_end_op = (imem_rd_data[INST_DATA_WIDTH-1 -: OPCODE_W] == BLOCK_END_OPCODE);
    at_max    = (rsp_ptr == {INST_ADDR_WIDTH{1'b1}});
    end_now   = rsp_ok && (is_end_op || at_max);
    // Occupancy includes the outstanding request, so a response always has a slot.
    has_room  = ({1'b0, count} + {{CW{1'b0}}, pend}) < (CW+1)'(FIFO_DEPTH);
    issue     = (state == S_FETCH) && !rsp_drop && !end_now && has_room;
    pop       = inst_valid && inst_ready;
  end

  assign imem_rd_req  = issue;
  assign imem_rd_addr = iss_ptr;
  assign inst_valid   = (count != '0);
  assign inst_data    = mem[rd_ptr];
  assign busy         = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= S_IDLE;
      iss_ptr            <= '0;
      rsp_ptr            <= '0;
      pend               <= 1'b0;
      nblk               <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      imem_rd_block_done <= 1'b0;
      done               <= 1'b0;
      blocks_done        <= '0;
      err_no_end         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pend               <= issue;
      imem_rd_block_done <= 1'b0;

      if (issue) iss_ptr <= iss_ptr + 1'b1;
      else if (rsp_drop) iss_ptr <= rsp_ptr;

      if (rsp_ok) begin
        mem[wr_ptr] <= imem_rd_data;
        wr_ptr      <= wr_ptr + 1'b1;
        rsp_ptr     <= rsp_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({rsp_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_WAIT_BLK;
            nblk        <= num_blocks;
            blocks_done <= '0;
            err_no_end  <= 1'b0;
            done        <= 1'b0;
          end
        end
        S_WAIT_BLK: begin
          if (imem_block_ready) begin
            state   <= S_FETCH;
            iss_ptr <= '0;
            rsp_ptr <= '0;
          end
        end
        S_FETCH: begin
          if (end_now) begin
            state <= S_DRAIN;
            if (!is_end_op) err_no_end <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (count == '0 && !pend) begin
            state              <= S_RETIRE;
            imem_rd_block_done <= 1'b1;
          end
        end
        S_RETIRE: begin
          blocks_done <= blocks_done + 16'd1;
          if (nblk != 16'd0 && (blocks_done + 16'd1) == nblk) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT_BLK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
